// File: rtl/prio_encoder_8_to_3_if.sv
`default_nettype none
// ============================================================================
//  Module   : prio_encoder_8_to_3_if
//  Brief    : Request/grant bundle between event sources, the priority
//             encoder and its single consumer.
//  Revision : 1.0 - initial release
// ============================================================================
interface prio_encoder_8_to_3_if #(
    parameter int N = 8,
    parameter int W = 3
);
    logic         en;
    logic [N-1:0] D;
    logic         ready;
    logic [W-1:0] A;
    logic         valid;
    logic [N-1:0] pend;
    logic         ovf;

    modport master (
        output en, D, ready,
        input  A, valid, pend, ovf
    );

    modport slave (
        input  en, D, ready,
        output A, valid, pend, ovf
    );
endinterface
`default_nettype wire

// File: rtl/prio_encoder_8_to_3.sv
`default_nettype none
// ============================================================================
//  Module   : prio_encoder_8_to_3
//  Brief    : Sticky pending register drained MSB-first through a valid/ready
//             handshake; flags requests that land on an uncleared bit.
//  Revision : 1.0 - initial release
// ============================================================================
module prio_encoder_8_to_3 #(
    parameter int N = 8,
    parameter int W = 3
) (
    input  wire logic             clk,
    input  wire logic             rst,
    prio_encoder_8_to_3_if.slave  bus
);

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_HOLD = 1'b1
    } state_t;

    localparam logic [N-1:0] c_ONE = {{(N-1){1'b0}}, 1'b1};

    state_t       r_state;
    state_t       w_state_next;
    logic [W-1:0] r_A;
    logic [W-1:0] w_A_next;
    logic [N-1:0] r_pend;
    logic [N-1:0] w_pend_next;
    logic         r_ovf;
    logic         w_ovf_hit;
    logic [N-1:0] w_grant_onehot;
    logic [N-1:0] w_clr;
    logic [N-1:0] w_set;
    logic [N-1:0] w_rem;

    // Highest set index wins; scanning upward lets later bits overwrite.
    function automatic logic [W-1:0] f_top_index(input logic [N-1:0] vec);
        logic [W-1:0] idx;
        idx = '0;
        for (int i = 0; i < N; i++) begin
            if (vec[i]) idx = W'(i);
        end
        return idx;
    endfunction

    always_comb begin
        w_grant_onehot = c_ONE << r_A;
        w_clr          = '0;
        if (r_state == S_HOLD && bus.ready) w_clr = w_grant_onehot;
        w_set          = bus.en ? bus.D : '0;
        // Set is OR-ed after the clear so a coincident re-request survives.
        w_pend_next    = (r_pend & ~w_clr) | w_set;
        w_ovf_hit      = |(w_set & r_pend & ~w_clr);
        w_rem          = r_pend & ~w_grant_onehot;
    end

    always_comb begin
        w_state_next = r_state;
        w_A_next     = r_A;
        case (r_state)
            S_IDLE: begin
                if (|r_pend) begin
                    w_state_next = S_HOLD;
                    w_A_next     = f_top_index(r_pend);
                end
            end
            S_HOLD: begin
                // Without ready the offer is frozen; no preemption.
                if (bus.ready) begin
                    if (|w_rem) begin
                        w_A_next = f_top_index(w_rem);
                    end else begin
                        w_state_next = S_IDLE;
                        w_A_next     = '0;
                    end
                end
            end
            default: begin
                w_state_next = S_IDLE;
                w_A_next     = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_A     <= '0;
            r_pend  <= '0;
            r_ovf   <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_A     <= w_A_next;
            r_pend  <= w_pend_next;
            r_ovf   <= r_ovf | w_ovf_hit;
        end
    end

    assign bus.A     = r_A;
    assign bus.valid = (r_state == S_HOLD);
    assign bus.pend  = r_pend;
    assign bus.ovf   = r_ovf;

endmodule
`default_nettype wire

// File: tb/tb_prio_encoder_8_to_3.sv
`default_nettype none
// ============================================================================
//  Module   : tb_prio_encoder_8_to_3
//  Brief    : Directed vector table plus randomized traffic against a
//             reference model, both checked through an expectation queue.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_prio_encoder_8_to_3;

    typedef struct {
        logic       rst;
        logic       en;
        logic [7:0] d;
        logic       ready;
        logic [2:0] a;
        logic       valid;
        logic [7:0] pend;
        logic       ovf;
    } vec_t;

    typedef struct {
        logic [2:0] a;
        logic       valid;
        logic [7:0] pend;
        logic       ovf;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    int   total = 0;
    int   bad   = 0;

    vec_t vt[$];
    exp_t sb[$];

    // Reference model state for the random phase
    logic [2:0] m_a;
    logic       m_valid;
    logic [7:0] m_pend;
    logic       m_ovf;

    prio_encoder_8_to_3_if #(.N(8), .W(3)) bus ();

    prio_encoder_8_to_3 #(.N(8), .W(3)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    function automatic vec_t mk(input logic r, input logic e, input logic [7:0] d,
                                input logic rd, input logic [2:0] a, input logic v,
                                input logic [7:0] p, input logic o);
        vec_t x;
        x.rst = r; x.en = e; x.d = d; x.ready = rd;
        x.a = a; x.valid = v; x.pend = p; x.ovf = o;
        return x;
    endfunction

    function automatic logic [2:0] top_bit(input logic [7:0] v);
        for (int i = 7; i >= 0; i--) begin
            if (v[i]) return 3'(i);
        end
        return 3'd0;
    endfunction

    task automatic chk(input string name, input int idx, input logic [7:0] act, input logic [7:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s step=%0d got=%0h want=%0h", name, idx, act, exp);
        end
    endtask

    // Drive one cycle, queue its expectation, then compare after the edge.
    task automatic cycle(input int idx, input logic r, input logic e, input logic [7:0] d,
                         input logic rd, input exp_t ex);
        exp_t got;
        rst      = r;
        bus.en   = e;
        bus.D    = d;
        bus.ready = rd;
        sb.push_back(ex);
        @(posedge clk);
        #1;
        if (sb.size() == 0) begin
            total++; bad++;
            $display("FAIL scoreboard_empty step=%0d got=0 want=1", idx);
        end else begin
            got = sb.pop_front();
            chk("A",     idx, {5'd0, bus.A},     {5'd0, got.a});
            chk("valid", idx, {7'd0, bus.valid}, {7'd0, got.valid});
            chk("pend",  idx, bus.pend,          got.pend);
            chk("ovf",   idx, {7'd0, bus.ovf},   {7'd0, got.ovf});
        end
    endtask

    task automatic model_step(input logic r, input logic e, input logic [7:0] d, input logic rd);
        logic [7:0] clr, setv, rem;
        clr  = (m_valid && rd) ? (8'd1 << m_a) : 8'd0;
        setv = e ? d : 8'd0;
        if (r) begin
            m_a = 3'd0; m_valid = 1'b0; m_pend = 8'd0; m_ovf = 1'b0;
        end else begin
            rem   = m_pend & ~clr;
            m_ovf = m_ovf | (|(setv & m_pend & ~clr));
            if (!m_valid) begin
                if (m_pend != 8'd0) begin
                    m_valid = 1'b1;
                    m_a     = top_bit(m_pend);
                end
            end else if (rd) begin
                if (rem != 8'd0) m_a = top_bit(rem);
                else begin m_valid = 1'b0; m_a = 3'd0; end
            end
            m_pend = rem | setv;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        exp_t ex;
        logic r, e, rd;
        logic [7:0] d;

        rst = 1'b1; bus.en = 1'b0; bus.D = 8'h00; bus.ready = 1'b0;

        //            rst  en   D      rdy  | A     vld  pend   ovf
        // reset with requests present
        vt.push_back(mk(1'b1, 1'b1, 8'hFF, 1'b0, 3'd0, 1'b0, 8'h00, 1'b0));
        vt.push_back(mk(1'b1, 1'b1, 8'hFF, 1'b0, 3'd0, 1'b0, 8'h00, 1'b0));
        // single request, valid for exactly one cycle
        vt.push_back(mk(1'b0, 1'b1, 8'h04, 1'b1, 3'd0, 1'b0, 8'h04, 1'b0));
        vt.push_back(mk(1'b0, 1'b0, 8'h00, 1'b1, 3'd2, 1'b1, 8'h04, 1'b0));
        vt.push_back(mk(1'b0, 1'b0, 8'h00, 1'b1, 3'd0, 1'b0, 8'h00, 1'b0));
        vt.push_back(mk(1'b0, 1'b0, 8'h00, 1'b1, 3'd0, 1'b0, 8'h00, 1'b0));
        // backlog 0x95 held, then drained 7,4,2,0
        vt.push_back(mk(1'b0, 1'b1, 8'h95, 1'b0, 3'd0, 1'b0, 8'h95, 1'b0));
        for (int i = 0; i < 5; i++)
            vt.push_back(mk(1'b0, 1'b0, 8'h00, 1'b0, 3'd7, 1'b1, 8'h95, 1'b0));
        vt.push_back(mk(1'b0, 1'b0, 8'h00, 1'b1, 3'd4, 1'b1, 8'h15, 1'b0));
        vt.push_back(mk(1'b0, 1'b0, 8'h00, 1'b1, 3'd2, 1'b1, 8'h05, 1'b0));
        vt.push_back(mk(1'b0, 1'b0, 8'h00, 1'b1, 3'd0, 1'b1, 8'h01, 1'b0));
        vt.push_back(mk(1'b0, 1'b0, 8'h00, 1'b1, 3'd0, 1'b0, 8'h00, 1'b0));
        // enable gating
        for (int i = 0; i < 4; i++)
            vt.push_back(mk(1'b0, 1'b0, 8'hFF, 1'b0, 3'd0, 1'b0, 8'h00, 1'b0));
        // overflow on held bit 3, sticky until reset
        vt.push_back(mk(1'b0, 1'b1, 8'h08, 1'b0, 3'd0, 1'b0, 8'h08, 1'b0));
        vt.push_back(mk(1'b0, 1'b0, 8'h00, 1'b0, 3'd3, 1'b1, 8'h08, 1'b0));
        vt.push_back(mk(1'b0, 1'b1, 8'h08, 1'b0, 3'd3, 1'b1, 8'h08, 1'b1));
        vt.push_back(mk(1'b0, 1'b0, 8'h00, 1'b0, 3'd3, 1'b1, 8'h08, 1'b1));
        vt.push_back(mk(1'b0, 1'b0, 8'h00, 1'b1, 3'd0, 1'b0, 8'h00, 1'b1));
        vt.push_back(mk(1'b1, 1'b0, 8'h00, 1'b0, 3'd0, 1'b0, 8'h00, 1'b0));
        // set and clear on the same edge: set wins, no overflow, re-offered
        vt.push_back(mk(1'b0, 1'b1, 8'h08, 1'b0, 3'd0, 1'b0, 8'h08, 1'b0));
        vt.push_back(mk(1'b0, 1'b0, 8'h00, 1'b0, 3'd3, 1'b1, 8'h08, 1'b0));
        vt.push_back(mk(1'b0, 1'b1, 8'h08, 1'b1, 3'd0, 1'b0, 8'h08, 1'b0));
        vt.push_back(mk(1'b0, 1'b0, 8'h00, 1'b1, 3'd3, 1'b1, 8'h08, 1'b0));
        vt.push_back(mk(1'b0, 1'b0, 8'h00, 1'b1, 3'd0, 1'b0, 8'h00, 1'b0));
        // reset in the middle of a backlog
        vt.push_back(mk(1'b0, 1'b1, 8'h95, 1'b0, 3'd0, 1'b0, 8'h95, 1'b0));
        vt.push_back(mk(1'b0, 1'b0, 8'h00, 1'b0, 3'd7, 1'b1, 8'h95, 1'b0));
        vt.push_back(mk(1'b1, 1'b0, 8'h00, 1'b1, 3'd0, 1'b0, 8'h00, 1'b0));
        vt.push_back(mk(1'b0, 1'b0, 8'h00, 1'b1, 3'd0, 1'b0, 8'h00, 1'b0));
        vt.push_back(mk(1'b0, 1'b0, 8'h00, 1'b1, 3'd0, 1'b0, 8'h00, 1'b0));
        // persistent level on bit 0: overflow while pending, re-granted
        vt.push_back(mk(1'b0, 1'b1, 8'h01, 1'b1, 3'd0, 1'b0, 8'h01, 1'b0));
        vt.push_back(mk(1'b0, 1'b1, 8'h01, 1'b1, 3'd0, 1'b1, 8'h01, 1'b1));
        vt.push_back(mk(1'b0, 1'b1, 8'h01, 1'b1, 3'd0, 1'b0, 8'h01, 1'b1));
        vt.push_back(mk(1'b0, 1'b0, 8'h00, 1'b1, 3'd0, 1'b1, 8'h01, 1'b1));
        vt.push_back(mk(1'b0, 1'b0, 8'h00, 1'b1, 3'd0, 1'b0, 8'h00, 1'b1));
        // higher bit arriving during a stalled offer does not preempt
        vt.push_back(mk(1'b1, 1'b0, 8'h00, 1'b0, 3'd0, 1'b0, 8'h00, 1'b0));
        vt.push_back(mk(1'b0, 1'b1, 8'h08, 1'b0, 3'd0, 1'b0, 8'h08, 1'b0));
        vt.push_back(mk(1'b0, 1'b1, 8'h80, 1'b0, 3'd3, 1'b1, 8'h88, 1'b0));
        vt.push_back(mk(1'b0, 1'b0, 8'h00, 1'b0, 3'd3, 1'b1, 8'h88, 1'b0));
        vt.push_back(mk(1'b0, 1'b0, 8'h00, 1'b1, 3'd7, 1'b1, 8'h80, 1'b0));
        vt.push_back(mk(1'b0, 1'b0, 8'h00, 1'b1, 3'd0, 1'b0, 8'h00, 1'b0));
        // all lines pending: drains 7 down to 0
        vt.push_back(mk(1'b0, 1'b1, 8'hFF, 1'b1, 3'd0, 1'b0, 8'hFF, 1'b0));
        vt.push_back(mk(1'b0, 1'b0, 8'h00, 1'b1, 3'd7, 1'b1, 8'hFF, 1'b0));
        for (int i = 6; i >= 0; i--)
            vt.push_back(mk(1'b0, 1'b0, 8'h00, 1'b1, 3'(i), 1'b1, 8'hFF >> (7 - i), 1'b0));
        vt.push_back(mk(1'b0, 1'b0, 8'h00, 1'b1, 3'd0, 1'b0, 8'h00, 1'b0));

        foreach (vt[k]) begin
            ex.a = vt[k].a; ex.valid = vt[k].valid; ex.pend = vt[k].pend; ex.ovf = vt[k].ovf;
            cycle(k, vt[k].rst, vt[k].en, vt[k].d, vt[k].ready, ex);
        end

        // Randomized traffic checked against the reference model
        m_a = 3'd0; m_valid = 1'b0; m_pend = 8'd0; m_ovf = 1'b0;
        for (int k = 0; k < 300; k++) begin
            r  = (k == 0) || ($urandom_range(0, 59) == 0);
            e  = ($urandom_range(0, 3) != 0);
            d  = ($urandom_range(0, 2) == 0) ? 8'($urandom) : 8'h00;
            rd = ($urandom_range(0, 3) != 0);
            model_step(r, e, d, rd);
            ex.a = m_a; ex.valid = m_valid; ex.pend = m_pend; ex.ovf = m_ovf;
            cycle(1000 + k, r, e, d, rd, ex);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
